decode_issue_queue: RTL

//  Parametrised in-order issue queue between the renaming decode stage and the execute pipes.

---
 rtl/decode_issue_queue_pkg.sv | 27 ++
 rtl/decode_issue_queue_wakeup_cam.sv | 28 ++
 rtl/decode_issue_queue.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/decode_issue_queue_pkg.sv
// Shared types for the decode issue queue: default geometry, entry layout and age compare.
// The entry struct follows the package widths; the queue's default parameters match them.
package decode_issue_queue_pkg;
    localparam int unsigned DEPTH         = 4;
    localparam int unsigned NUM_PHYS_REGS = 36;
    localparam int unsigned SEQ_NUM_BITS  = 5;
    localparam int unsigned DATA_BITS     = 128;
    localparam int unsigned PREG_BITS     = $clog2(NUM_PHYS_REGS);
    localparam int unsigned IDX_BITS      = $clog2(DEPTH);
    localparam int unsigned PTR_BITS      = IDX_BITS + 1;
    localparam int unsigned CNT_BITS      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_BITS-1:0]            data;
        logic [SEQ_NUM_BITS-1:0]         seq_num;
        logic [1:0][PREG_BITS-1:0]       psrc;
        logic [1:0]                      pend;
    } iq_entry_t;

    // True when e is strictly younger than s, modulo the sequence-number space.
    function automatic logic seq_younger(input logic [SEQ_NUM_BITS-1:0] e,
                                         input logic [SEQ_NUM_BITS-1:0] s);
        logic [SEQ_NUM_BITS-1:0] diff;
        diff = e - s;
        return (diff[SEQ_NUM_BITS-1] == 1'b0) && (diff != {SEQ_NUM_BITS{1'b0}});
    endfunction
endpackage

// File: rtl/decode_issue_queue_wakeup_cam.sv
// Per-entry source-preg compare against the completion broadcast; yields pending-bit clear masks.
module iq_wakeup_cam #(
    parameter int unsigned p_depth     = 4,
    parameter int unsigned p_preg_bits = 6
) (
    input  logic                             complete_val,
    input  logic                             complete_wen,
    input  logic [p_preg_bits-1:0]           complete_preg,
    input  logic [p_depth*p_preg_bits-1:0]   psrc0,
    input  logic [p_depth*p_preg_bits-1:0]   psrc1,
    output logic [p_depth-1:0]               clr0,
    output logic [p_depth-1:0]               clr1
);
    // Match every slot's two sources against the completing destination
    always_comb begin
        clr0 = {p_depth{1'b0}};
        clr1 = {p_depth{1'b0}};
        for (int i = 0; i < p_depth; i++) begin
            if (complete_val && complete_wen) begin
                clr0[i] = (psrc0[i*p_preg_bits +: p_preg_bits] == complete_preg);
                clr1[i] = (psrc1[i*p_preg_bits +: p_preg_bits] == complete_preg);
            end else begin
                clr0[i] = 1'b0;
                clr1[i] = 1'b0;
            end
        end
    end
endmodule

// File: rtl/decode_issue_queue.sv
// In-order issue queue between rename and execute, with wakeup and squash of younger entries.
// Optional same-cycle issue of an enqueue into an empty queue: define ISSUE_BYPASS_EN.
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter int unsigned p_depth         = DEPTH,
    parameter int unsigned p_num_phys_regs = NUM_PHYS_REGS,
    parameter int unsigned p_seq_num_bits  = SEQ_NUM_BITS,
    parameter int unsigned p_data_bits     = DATA_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enq_val,
    output logic                                 enq_rdy,
    input  logic [p_data_bits-1:0]               enq_data,
    input  logic [p_seq_num_bits-1:0]            enq_seq_num,
    input  logic [2*$clog2(p_num_phys_regs)-1:0] enq_psrc,
    input  logic [1:0]                           enq_pend,
    output logic                                 deq_val,
    input  logic                                 deq_rdy,
    output logic [p_data_bits-1:0]               deq_data,
    output logic [p_seq_num_bits-1:0]            deq_seq_num,
    output logic [2*$clog2(p_num_phys_regs)-1:0] deq_psrc,
    input  logic                                 complete_val,
    input  logic                                 complete_wen,
    input  logic [$clog2(p_num_phys_regs)-1:0]   complete_preg,
    input  logic                                 squash_val,
    input  logic [p_seq_num_bits-1:0]            squash_seq_num,
    output logic [$clog2(p_depth+1)-1:0]         count
);
    localparam int unsigned PBW = $clog2(p_num_phys_regs);
    localparam int unsigned IW  = $clog2(p_depth);
    localparam int unsigned PW  = IW + 1;
    localparam int unsigned CW  = $clog2(p_depth + 1);

    iq_entry_t         entries_q [p_depth];
    iq_entry_t         entries_d [p_depth];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              init_q, init_d;

    logic [IW-1:0]     head_idx_s, tail_idx_s, slot_s;
    logic              full_s, empty_s, head_younger_s, q_deq_val_s, wake_s;
    logic              enq_xfer_s, enq_write_s, deq_from_q_s, bypass_s;
    logic [1:0]        enq_pend_eff_s;
    logic [CW-1:0]     keep_s;
    logic [p_depth-1:0]     clr0_s, clr1_s;
    logic [p_depth*PBW-1:0] cam_psrc0_s, cam_psrc1_s;

    // Flatten stored sources for the wakeup compare
    always_comb begin
        cam_psrc0_s = {(p_depth*PBW){1'b0}};
        cam_psrc1_s = {(p_depth*PBW){1'b0}};
        for (int i = 0; i < p_depth; i++) begin
            cam_psrc0_s[i*PBW +: PBW] = entries_q[i].psrc[0];
            cam_psrc1_s[i*PBW +: PBW] = entries_q[i].psrc[1];
        end
    end

    iq_wakeup_cam #(.p_depth(p_depth), .p_preg_bits(PBW)) u_cam (
        .complete_val (complete_val),
        .complete_wen (complete_wen),
        .complete_preg(complete_preg),
        .psrc0        (cam_psrc0_s),
        .psrc1        (cam_psrc1_s),
        .clr0         (clr0_s),
        .clr1         (clr1_s)
    );

    // Queue status, issue selection, and handshake outputs
    always_comb begin
        head_idx_s     = head_q[IW-1:0];
        tail_idx_s     = tail_q[IW-1:0];
        full_s         = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
        empty_s        = (head_q == tail_q);
        head_younger_s = seq_younger(entries_q[head_idx_s].seq_num, squash_seq_num);
        q_deq_val_s    = !empty_s && !entries_q[head_idx_s].pend[0] &&
                         !entries_q[head_idx_s].pend[1] && !(squash_val && head_younger_s);
        wake_s         = complete_val && complete_wen;
        enq_pend_eff_s[0] = enq_pend[0] && !(wake_s && (enq_psrc[PBW-1:0] == complete_preg));
        enq_pend_eff_s[1] = enq_pend[1] && !(wake_s && (enq_psrc[2*PBW-1:PBW] == complete_preg));
        enq_rdy        = init_q && !full_s && !squash_val;
        enq_xfer_s     = enq_val && enq_rdy;
`ifdef ISSUE_BYPASS_EN
        bypass_s       = init_q && empty_s && enq_val && !squash_val && (enq_pend_eff_s == 2'b00);
`else
        bypass_s       = 1'b0;
`endif
        if (bypass_s) begin
            deq_val     = 1'b1;
            deq_data    = enq_data;
            deq_seq_num = enq_seq_num;
            deq_psrc    = enq_psrc;
        end else begin
            deq_val     = q_deq_val_s;
            deq_data    = entries_q[head_idx_s].data;
            deq_seq_num = entries_q[head_idx_s].seq_num;
            deq_psrc    = entries_q[head_idx_s].psrc;
        end
        deq_from_q_s   = q_deq_val_s && deq_rdy && !bypass_s;
        enq_write_s    = enq_xfer_s && !(bypass_s && deq_rdy);
        count          = count_q;
    end

    // Count surviving (not younger) entries from the head; younger ones sit contiguously at the tail
    always_comb begin
        keep_s = {CW{1'b0}};
        slot_s = {IW{1'b0}};
        for (int i = 0; i < p_depth; i++) begin
            slot_s = head_idx_s + IW'(i);
            if ((CW'(i) < count_q) && !seq_younger(entries_q[slot_s].seq_num, squash_seq_num)) begin
                keep_s = keep_s + CW'(1);
            end else begin
                keep_s = keep_s;
            end
        end
    end

    // Next pointers, count and entry contents
    always_comb begin
        init_d = 1'b1;
        head_d = head_q + {{(PW-1){1'b0}}, deq_from_q_s};
        if (squash_val) begin
            tail_d  = head_q + PW'(keep_s);
            count_d = keep_s - {{(CW-1){1'b0}}, deq_from_q_s};
        end else begin
            tail_d  = tail_q + {{(PW-1){1'b0}}, enq_write_s};
            count_d = count_q + {{(CW-1){1'b0}}, enq_write_s} - {{(CW-1){1'b0}}, deq_from_q_s};
        end
        for (int i = 0; i < p_depth; i++) begin
            entries_d[i]         = entries_q[i];
            entries_d[i].pend[0] = entries_q[i].pend[0] && !clr0_s[i];
            entries_d[i].pend[1] = entries_q[i].pend[1] && !clr1_s[i];
        end
        if (enq_write_s) begin
            entries_d[tail_idx_s].data    = enq_data;
            entries_d[tail_idx_s].seq_num = enq_seq_num;
            entries_d[tail_idx_s].psrc    = enq_psrc;
            entries_d[tail_idx_s].pend    = enq_pend_eff_s;
        end else begin
            entries_d[tail_idx_s] = entries_d[tail_idx_s];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            init_q  <= 1'b0;
            for (int i = 0; i < p_depth; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            init_q  <= init_d;
            for (int i = 0; i < p_depth; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end
endmodule
